// File: rtl/lhn_mul_seq_param.sv
// lhn_mul_seq_param: parametrised sequential shift-add multiplier with start/done handshake,
// optional two's-complement operands and optional early termination.
`default_nettype none

module lhn_mul_seq_param #(
  parameter int WIDTH      = 6,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               signed_mode_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplr_q,    mplr_d;
  logic [PW-1:0]    acc_q,     acc_d;
  logic [CW-1:0]    count_q,   count_d;
  logic             neg_q,     neg_d;
  logic [PW-1:0]    product_q, product_d;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplr_shift;
  logic             last_step;
  logic [PW-1:0]    result;

  // Most negative operand maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  always_comb begin
    mag_a = (signed_mode_i && multiplicand_i[WIDTH-1]) ? (-multiplicand_i) : multiplicand_i;
    mag_b = (signed_mode_i && multiplier_i[WIDTH-1])   ? (-multiplier_i)   : multiplier_i;
  end

  always_comb begin
    addend     = {{WIDTH{1'b0}}, mcand_q} << count_q;
    acc_sum    = mplr_q[0] ? (acc_q + addend) : acc_q;
    mplr_shift = mplr_q >> 1;
    last_step  = (count_q == LAST_COUNT) || (EARLY_EXIT && (mplr_shift == '0));
    result     = neg_q ? (-acc_sum) : acc_sum;
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    count_d   = count_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mcand_d = mag_a;
          mplr_d  = mag_b;
          neg_d   = signed_mode_i & (multiplicand_i[WIDTH-1] ^ multiplier_i[WIDTH-1]);
          acc_d   = '0;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_sum;
        mplr_d  = mplr_shift;
        count_d = count_q + CW'(1);
        if (last_step) begin
          product_d = result;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product_o = product_q;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);

endmodule

`default_nettype wire
